// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, with optional early exit.
// Latency: done is high k cycles after accept (k = chunks_used). start is ignored while busy.
module seq_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    output logic                               busy,
    output logic                               done,
    output logic                               equal,
    output logic                               a_more,
    output logic                               b_more,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]   chunks_used
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              diff_q, diff_d;
    logic              gt_q, gt_d;
    logic              done_d, equal_d, a_more_d, b_more_d;
    logic [CW-1:0]     used_d;

    logic [CHUNK-1:0]  chunk_a, chunk_b;
    logic              new_diff;
    logic              finish;

    // Operands are shifted left each cycle, so the active chunk always sits at the top.
    assign chunk_a  = opa_q[WIDTH-1 -: CHUNK];
    assign chunk_b  = opb_q[WIDTH-1 -: CHUNK];
    assign new_diff = !diff_q && (chunk_a != chunk_b);
    assign busy     = (state_q == SCAN);

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        gt_d     = gt_q;
        done_d   = 1'b0;
        equal_d  = equal;
        a_more_d = a_more;
        b_more_d = b_more;
        used_d   = chunks_used;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    opa_d   = a ^ ({WIDTH{signed_mode}} & MSB_MASK);
                    opb_d   = b ^ ({WIDTH{signed_mode}} & MSB_MASK);
                    idx_d   = '0;
                    diff_d  = 1'b0;
                    gt_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                diff_d = diff_q | new_diff;
                gt_d   = new_diff ? (chunk_a > chunk_b) : gt_q;
                finish = (EARLY_EXIT && new_diff) || (idx_q == LAST_IDX);
                if (finish) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    equal_d  = !diff_d;
                    a_more_d = diff_d && gt_d;
                    b_more_d = diff_d && !gt_d;
                    used_d   = CW'(idx_q) + CW'(1);
                end else begin
                    idx_d = idx_q + IW'(1);
                    opa_d = opa_q << CHUNK;
                    opb_d = opb_q << CHUNK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            idx_q       <= '0;
            diff_q      <= 1'b0;
            gt_q        <= 1'b0;
            done        <= 1'b0;
            equal       <= 1'b0;
            a_more      <= 1'b0;
            b_more      <= 1'b0;
            chunks_used <= '0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            gt_q        <= gt_d;
            done        <= done_d;
            equal       <= equal_d;
            a_more      <= a_more_d;
            b_more      <= b_more_d;
            chunks_used <= used_d;
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Randomised bench for seq_mag_comparator: early-exit, fixed-latency and single-chunk instances
// checked against an arithmetic reference model.
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic       busy_e, done_e, eq_e, am_e, bm_e;
    logic [2:0] cu_e;
    logic       busy_f, done_f, eq_f, am_f, bm_f;
    logic [2:0] cu_f;
    logic       busy_o, done_o, eq_o, am_o, bm_o;
    logic [0:0] cu_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy_e), .done(done_e), .equal(eq_e), .a_more(am_e), .b_more(bm_e), .chunks_used(cu_e));

    seq_mag_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) u_fx (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy_f), .done(done_f), .equal(eq_f), .a_more(am_f), .b_more(bm_f), .chunks_used(cu_f));

    seq_mag_comparator #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1'b1)) u_one (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy_o), .done(done_o), .equal(eq_o), .a_more(am_o), .b_more(bm_o), .chunks_used(cu_o));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result from plain (signed) arithmetic; chunk count from the highest differing bit.
    task automatic model(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                         input int chunk, input bit ee,
                         output logic [2:0] res, output int used);
        logic [15:0] x;
        int p;
        if (av == bv)                               res = 3'b100;
        else if (sm ? ($signed(av) > $signed(bv)) : (av > bv)) res = 3'b010;
        else                                        res = 3'b001;
        x = av ^ bv;
        p = -1;
        for (int i = 0; i < 16; i++) if (x[i]) p = i;
        if (!ee || p < 0) used = 16 / chunk;
        else              used = (15 - p) / chunk + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmp(input logic sm, input logic [15:0] av, input logic [15:0] bv);
        int          lat  [3];
        logic [2:0]  res  [3];
        int          used [3];
        logic [2:0]  eres;
        int          eused;
        string       nm   [3];
        nm = '{"ee", "fx", "one"};
        for (int i = 0; i < 3; i++) begin lat[i] = 0; res[i] = '0; used[i] = 0; end
        start = 1'b1; signed_mode = sm; a = av; b = bv;
        tick();
        start = 1'b0;
        signed_mode = ~sm; a = ~av; b = ~bv;
        check("fx_busy_after_accept", {31'd0, busy_f}, 32'd1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) tick();
            if (cyc == 1) begin
                @(posedge clk);
                #1;
            end
            if (done_e && lat[0] == 0) begin lat[0] = cyc; res[0] = {eq_e, am_e, bm_e}; used[0] = int'(cu_e); end
            if (done_f && lat[1] == 0) begin lat[1] = cyc; res[1] = {eq_f, am_f, bm_f}; used[1] = int'(cu_f); end
            if (done_o && lat[2] == 0) begin lat[2] = cyc; res[2] = {eq_o, am_o, bm_o}; used[2] = int'(cu_o); end
        end
        for (int i = 0; i < 3; i++) begin
            model(sm, av, bv, (i == 2) ? 16 : 4, (i != 1), eres, eused);
            check({nm[i], "_latency"}, lat[i], eused);
            check({nm[i], "_eq_am_bm"}, {29'd0, res[i]}, {29'd0, eres});
            check({nm[i], "_chunks_used"}, used[i], eused);
        end
    endtask

    initial begin
        int         ndone;
        logic       hold_am;
        logic [2:0] hold_cu;
        int         lat;
        logic [15:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy_e | busy_f | busy_o}, 32'd0);
        check("rst_done",  {31'd0, done_e | done_f | done_o}, 32'd0);
        check("rst_res",   {29'd0, eq_e | eq_f | eq_o, am_e | am_f | am_o, bm_e | bm_f | bm_o}, 32'd0);
        check("rst_used",  {28'd0, cu_e | cu_f, cu_o}, 32'd0);
        reset = 1'b0;
        tick();

        run_cmp(1'b0, 16'h1234, 16'h1234);
        run_cmp(1'b0, 16'h8000, 16'h7FFF);
        run_cmp(1'b1, 16'h8000, 16'h7FFF);
        run_cmp(1'b1, 16'hFFFF, 16'hFFFE);
        run_cmp(1'b0, 16'h1235, 16'h1234);
        run_cmp(1'b1, 16'h0001, 16'hFFFF);

        // start while busy must be dropped; the fixed-latency instance should report only the first compare.
        ndone = 0; hold_am = 1'b0; hold_cu = '0;
        start = 1'b1; signed_mode = 1'b0; a = 16'h8000; b = 16'h7FFF;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 16'h0000; b = 16'hFFFF;
        tick();
        if (done_f) begin ndone++; hold_am = am_f; hold_cu = cu_f; end
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_f) begin ndone++; hold_am = am_f; hold_cu = cu_f; end
        end
        check("busy_start_done_count", ndone, 1);
        check("busy_start_a_more", {31'd0, hold_am}, 32'd1);
        check("busy_start_used", {29'd0, hold_cu}, 32'd4);

        // start held through the done cycle is accepted as a second compare.
        start = 1'b1; signed_mode = 1'b0; a = 16'h8000; b = 16'h7FFF;
        tick();
        a = 16'h0001; b = 16'h0002;
        tick();
        check("b2b_first_done", {31'd0, done_e}, 32'd1);
        check("b2b_first_a_more", {31'd0, am_e}, 32'd1);
        tick();
        start = 1'b0;
        check("b2b_second_busy", {31'd0, busy_e}, 32'd1);
        check("b2b_hold_result", {31'd0, am_e}, 32'd1);
        lat = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            if (done_e && lat == 0) begin
                lat = cyc;
                check("b2b_second_b_more", {31'd0, bm_e}, 32'd1);
                check("b2b_second_used", {29'd0, cu_e}, 32'd4);
            end
        end
        check("b2b_second_latency", lat, 4);

        // Reset after two chunks aborts the compare with no trailing done.
        start = 1'b1; a = 16'h1111; b = 16'h1112;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy_e | busy_f}, 32'd0);
        check("midrst_res",  {29'd0, eq_e | eq_f, am_e | am_f, bm_e | bm_f}, 32'd0);
        check("midrst_used", {29'd0, cu_e | cu_f}, 32'd0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_e || done_f || done_o) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_cmp(1'b0, 16'h1111, 16'h1112);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 16'($urandom_range(1, 15));
                2:       rb = ra ^ 16'($urandom_range(1, 255));
                default: rb = 16'($urandom);
            endcase
            run_cmp(1'($urandom_range(0, 1)), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
